// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared constants and helpers for the synchronous FIFO and its storage.
//
// Contents:
//   FIFO_DEFAULT_DEPTH : default number of entries (16)
//   ptr_width()        : address width for a given depth, never below one bit
//   count_width()      : occupancy width able to hold 0..depth inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int FIFO_DEFAULT_DEPTH = 16;

   // Address width for a storage array of 'depth' entries. A depth of one
   // would give $clog2 = 0, so the result is clamped to at least one bit to
   // keep every pointer a legal vector.
   function automatic int ptr_width(input int depth);
      int w;
      w = $clog2(depth);
      if (w < 1) begin
         w = 1;
      end
      return w;
   endfunction

   // Occupancy must represent both zero and 'depth', hence depth+1 states.
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// -----------------------------------------------------------------------------
// fifo_mem
// DEPTH x T storage for the FIFO. One synchronous write port and one
// synchronous read port whose output register only updates when a read is
// requested, so the last value read is held between reads. No reset: the
// array and the output register power up undefined and the controller masks
// the output until the first accepted read after reset.
//
// Ports:
//   clk       : clock, all updates on the rising edge
//   wr_en     : write strobe (already qualified by the controller)
//   wr_addr   : write address, 0..DEPTH-1
//   wr_data   : element to store
//   rd_en     : read strobe (already qualified by the controller)
//   rd_addr   : read address, 0..DEPTH-1
//   rd_data   : registered element read at the last rd_en edge
// -----------------------------------------------------------------------------
module fifo_mem
   import fifo_pkg::*;
#(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = FIFO_DEFAULT_DEPTH,
   parameter int  AW    = ptr_width(DEPTH)
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  T              wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output T              rd_data
);

   T mem [DEPTH];

   // Write port. The controller never presents an address >= DEPTH, so the
   // array index is always in range even for non power-of-two depths.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read port. Reading and writing the same address in one cycle
   // returns the old contents; the controller never reads an entry in the
   // same cycle it is written because writes into an empty FIFO are not
   // visible until the following cycle.
   always_ff @(posedge clk) begin
      if (rd_en) begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: rtl/fifo.sv
// -----------------------------------------------------------------------------
// fifo
// Single-clock first-in first-out buffer with a registered read port and no
// fall-through. Holds pointers, occupancy count, status flags and control;
// the entries themselves live in fifo_mem.
//
// Parameters:
//   T      : element type
//   DEPTH  : number of entries, 2..65536, any value
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   reset      : synchronous active-high reset, overrides read/write requests
//   write_en   : write request, accepted when not full
//   write_data : element to enqueue
//   read_en    : read request, accepted when not empty
//   read_data  : registered dequeued element, valid the cycle after an
//                accepted read and held until the next accepted read
//   full       : DEPTH entries stored
//   empty      : no entries stored
//   count      : current occupancy
// -----------------------------------------------------------------------------
module fifo
   import fifo_pkg::*;
#(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = FIFO_DEFAULT_DEPTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         write_en,
   input  T                             write_data,
   input  logic                         read_en,
   output T                             read_data,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int AW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr_next;
   logic [AW-1:0] rd_ptr_next;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_next;
   logic          full_q;
   logic          empty_q;
   logic          full_next;
   logic          empty_next;
   logic          wr_accept;
   logic          rd_accept;
   logic          out_cleared;
   T              mem_rd_data;

   // Requests are qualified against the registered flags, so a write into a
   // full FIFO or a read from an empty one simply never reaches storage.
   // A simultaneous read and write on a full FIFO therefore performs only
   // the read, and on an empty FIFO only the write.
   always_comb begin
      wr_accept = write_en && !full_q;
      rd_accept = read_en && !empty_q;
   end

   // Pointer advance with an explicit wrap compare so that depths which are
   // not powers of two cycle through exactly DEPTH addresses.
   always_comb begin
      wr_ptr_next = wr_ptr;
      rd_ptr_next = rd_ptr;
      if (wr_accept) begin
         wr_ptr_next = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + AW'(1);
      end
      if (rd_accept) begin
         rd_ptr_next = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + AW'(1);
      end
   end

   // Occupancy and the flags for the next cycle. Computing the flags from
   // the next count and registering them keeps full/empty free of
   // combinational glitches and mutually exclusive by construction.
   always_comb begin
      count_next = count_q;
      if (wr_accept && !rd_accept) begin
         count_next = count_q + CW'(1);
      end else if (rd_accept && !wr_accept) begin
         count_next = count_q - CW'(1);
      end
      full_next  = (count_next == FULL_COUNT);
      empty_next = (count_next == '0);
   end

   // Control state. Reset wins over any concurrent request and discards all
   // stored entries by collapsing both pointers and the count; the storage
   // array itself is left untouched. out_cleared forces read_data to zero
   // after reset until the first accepted read reloads the output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         full_q      <= 1'b0;
         empty_q     <= 1'b1;
         out_cleared <= 1'b1;
      end else begin
         wr_ptr  <= wr_ptr_next;
         rd_ptr  <= rd_ptr_next;
         count_q <= count_next;
         full_q  <= full_next;
         empty_q <= empty_next;
         if (rd_accept) begin
            out_cleared <= 1'b0;
         end
      end
   end

   // Storage. Strobes are gated by reset so a request coinciding with reset
   // does not disturb the array or the held output value.
   fifo_mem #(
      .T     (T),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_accept && !reset),
      .wr_addr (wr_ptr),
      .wr_data (write_data),
      .rd_en   (rd_accept && !reset),
      .rd_addr (rd_ptr),
      .rd_data (mem_rd_data)
   );

   // Output drive. The mask is a register, so read_data is still a purely
   // registered value after the final mux.
   always_comb begin
      read_data = out_cleared ? T'('0) : mem_rd_data;
      full      = full_q;
      empty     = empty_q;
      count     = count_q;
   end

endmodule

// File: tb/tb_fifo.sv
// -----------------------------------------------------------------------------
// tb_fifo
// Directed self-checking bench for fifo at its default parameters
// (8-bit elements, 16 entries). Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, i.e. after the edge that
// consumed the previous inputs has settled.
// -----------------------------------------------------------------------------
module tb_fifo;

   logic       clk;
   logic       reset;
   logic       write_en;
   logic [7:0] write_data;
   logic       read_en;
   logic [7:0] read_data;
   logic       full;
   logic       empty;
   logic [4:0] count;

   int checks;
   int errors;

   fifo dut (
      .clk        (clk),
      .reset      (reset),
      .write_en   (write_en),
      .write_data (write_data),
      .read_en    (read_en),
      .read_data  (read_data),
      .full       (full),
      .empty      (empty),
      .count      (count)
   );

   // 10 time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Compare all observable outputs against hand-computed values.
   task automatic check_state(input string name, input logic [7:0] exp_data,
                              input logic [4:0] exp_count,
                              input logic exp_full, input logic exp_empty);
      checks++;
      if (read_data !== exp_data || count !== exp_count ||
          full !== exp_full || empty !== exp_empty) begin
         errors++;
         $display("[TB] FAIL %s: got data=%h count=%0d full=%b empty=%b, expected data=%h count=%0d full=%b empty=%b",
                  name, read_data, count, full, empty,
                  exp_data, exp_count, exp_full, exp_empty);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; write_en = 1'b0; read_en = 1'b0; write_data = 8'h00;
      tick();
      tick();
      reset = 1'b0;
      check_state("reset", 8'h00, 5'd0, 1'b0, 1'b1);
   endtask

   // Writes 0x00..0x0F into an empty FIFO; read_data stays at 'hold'.
   task automatic test_fill(input logic [7:0] hold);
      for (int i = 0; i < 16; i++) begin
         write_en = 1'b1; write_data = 8'(i);
         tick();
         check_state($sformatf("fill[%0d]", i), hold, 5'(i + 1), i == 15, 1'b0);
      end
      write_en = 1'b0;
   endtask

   task automatic test_drain();
      for (int i = 0; i < 16; i++) begin
         read_en = 1'b1;
         tick();
         check_state($sformatf("drain[%0d]", i), 8'(i), 5'(15 - i), 1'b0, i == 15);
      end
      read_en = 1'b0;
   endtask

   task automatic test_overflow_underflow();
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check_state("underflow", 8'h0F, 5'd0, 1'b0, 1'b1);
      test_fill(8'h0F);
      write_en = 1'b1; write_data = 8'hFF;
      tick();
      write_en = 1'b0;
      check_state("overflow", 8'h0F, 5'd16, 1'b1, 1'b0);
      test_drain();
   endtask

   task automatic test_wrap();
      logic [7:0] prev;
      prev = 8'h0F;
      for (int i = 0; i < 32; i++) begin
         write_en = 1'b1; write_data = 8'(8'hA0 + i);
         tick();
         write_en = 1'b0;
         check_state($sformatf("wrap_wr[%0d]", i), prev, 5'd1, 1'b0, 1'b0);
         read_en = 1'b1;
         tick();
         read_en = 1'b0;
         prev = 8'(8'hA0 + i);
         check_state($sformatf("wrap_rd[%0d]", i), prev, 5'd0, 1'b0, 1'b1);
      end
   endtask

   task automatic test_back_to_back();
      // Eight entries 0x10..0x17, read_data holds 0xBF from the wrap test.
      for (int i = 0; i < 8; i++) begin
         write_en = 1'b1; write_data = 8'(8'h10 + i);
         tick();
      end
      write_en = 1'b0;
      check_state("half", 8'hBF, 5'd8, 1'b0, 1'b0);
      // Simultaneous read/write at 8 entries.
      write_en = 1'b1; read_en = 1'b1; write_data = 8'h18;
      tick();
      write_en = 1'b0; read_en = 1'b0;
      check_state("simul_mid", 8'h10, 5'd8, 1'b0, 1'b0);
      // Top up to full with 0x19..0x20; stored now 0x11..0x20.
      for (int i = 0; i < 8; i++) begin
         write_en = 1'b1; write_data = 8'(8'h19 + i);
         tick();
      end
      write_en = 1'b0;
      check_state("topup", 8'h10, 5'd16, 1'b1, 1'b0);
      // At full only the read happens; 0x55 must be dropped.
      write_en = 1'b1; read_en = 1'b1; write_data = 8'h55;
      tick();
      write_en = 1'b0; read_en = 1'b0;
      check_state("simul_full", 8'h11, 5'd15, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) begin
         read_en = 1'b1;
         tick();
         check_state($sformatf("simul_drain[%0d]", i), 8'(8'h12 + i), 5'(14 - i), 1'b0, i == 14);
      end
      read_en = 1'b0;
      // At empty only the write happens and read_data holds.
      write_en = 1'b1; read_en = 1'b1; write_data = 8'h66;
      tick();
      write_en = 1'b0; read_en = 1'b0;
      check_state("simul_empty", 8'h20, 5'd1, 1'b0, 1'b0);
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check_state("simul_empty_rd", 8'h66, 5'd0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         write_en = 1'b1; write_data = 8'(8'h30 + i);
         tick();
      end
      write_en = 1'b0;
      check_state("pre_reset", 8'h66, 5'd5, 1'b0, 1'b0);
      reset = 1'b1; write_en = 1'b1; read_en = 1'b1; write_data = 8'h77;
      tick();
      reset = 1'b0; write_en = 1'b0; read_en = 1'b0;
      check_state("mid_reset", 8'h00, 5'd0, 1'b0, 1'b1);
      write_en = 1'b1; write_data = 8'h88;
      tick();
      write_en = 1'b0;
      check_state("post_reset_wr", 8'h00, 5'd1, 1'b0, 1'b0);
      read_en = 1'b1;
      tick();
      read_en = 1'b0;
      check_state("post_reset_rd", 8'h88, 5'd0, 1'b0, 1'b1);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fill(8'h00);
      test_drain();
      test_overflow_underflow();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo.md
FIFO -- requirements
Module: fifo

Interface
REQ-001 SHALL have type parameter T, default logic [7:0]; the element type stored and returned.
REQ-002 SHALL have int parameter DEPTH, default 16; number of entries, legal range 2..65536, any value (not restricted to powers of two).
REQ-003 SHALL have port clk, input, 1 bit; single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit; synchronous, active-high reset.
REQ-005 SHALL have port write_en, input, 1 bit; write request.
REQ-006 SHALL have port write_data, input, T; element to enqueue.
REQ-007 SHALL have port read_en, input, 1 bit; read request.
REQ-008 SHALL have port read_data, output, T; registered dequeued element.
REQ-009 SHALL have port full, output, 1 bit; high when DEPTH entries stored.
REQ-010 SHALL have port empty, output, 1 bit; high when zero entries stored.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1) bits; current occupancy (may be left unconnected).

Function
REQ-012 Write accepted at a rising edge iff write_en=1 and full=0 (pre-edge value); write_data stored at write pointer, pointer advances.
REQ-013 Read accepted at a rising edge iff read_en=1 and empty=0 (pre-edge value); entry at read pointer loaded into read_data at that same edge, pointer advances; read_data valid from just after that edge (1-cycle registered latency).
REQ-014 No fall-through: a write into an empty FIFO is not readable until the following cycle.
REQ-015 Rejected write (full) SHALL be dropped with no state change; rejected read (empty) SHALL leave read_data and pointers unchanged.
REQ-016 read_data SHALL hold its last value whenever no read is accepted.
REQ-017 Order SHALL be strict first-in first-out.
REQ-018 Pointers SHALL wrap from DEPTH-1 to 0 (explicit compare, not power-of-two masking).
REQ-019 Simultaneous accepted read and write: both take effect, count unchanged; when full only the read is accepted, when empty only the write.
REQ-020 count +1 on write-only, -1 on read-only, unchanged otherwise; full = (count==DEPTH), empty = (count==0), both registered/derived from registered state, glitch-free.
REQ-021 full and empty SHALL never both be 1.

Reset
REQ-022 With reset=1 at a rising edge: read/write pointers=0, count=0, empty=1, full=0, read_data='0.
REQ-023 Reset SHALL take priority over concurrent write_en/read_en; reset mid-operation discards all stored entries.
REQ-024 Storage array contents need not be cleared by reset.

Structure
REQ-025 Package fifo_pkg SHALL hold default DEPTH constant (16) and a pointer-width helper function (max(1,$clog2(DEPTH))).
REQ-026 Storage SHALL be a sub-module fifo_mem: DEPTH x T, one synchronous write port, one synchronous registered read port, no reset; fifo contains pointers, count, flags and control.

Verification
REQ-027 Fill: after reset write 0x00..0x0F one per cycle -> empty=0 after first write, full=1 after 16th, count=16.
REQ-028 Drain: read 16 times from full -> read_data 0x00..0x0F in order, each valid 1 cycle after read_en edge, empty=1 after 16th.
REQ-029 Overflow/underflow: write 0xFF when full -> dropped, next reads unchanged; read when empty -> read_data holds last value (0x0F), flags unchanged.
REQ-030 Wrap: 32 iterations write 0xA0+i then read -> each read returns 0xA0+i, pointers wrap twice, ends empty.
REQ-031 Simultaneous: with 8 entries assert write_en and read_en same cycle -> count stays 8, oldest entry returned; at full only read occurs, at empty only write.
REQ-032 Reset mid-operation: after 5 writes assert reset one cycle -> empty=1, full=0, count=0, read_data=0x00, next write/read returns new data.
